// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared LED matrix geometry, row type and scan state encoding
package matrix_pkg;

  localparam int NUM_ROWS = 16;
  localparam int NUM_COLS = 16;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  typedef logic [NUM_COLS-1:0] row_t;

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - clearable up-counter flagging when it reaches a terminal value
module scan_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: restart from zero on clear, otherwise advance by one
  always_comb begin
    count_d = count_q + W'(1);
    if (clear_i) begin
      count_d = '0;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == last_i);

endmodule

// File: rtl/led_row_scanner.sv
// rtl/led_row_scanner.sv - row-multiplexed 16x16 LED matrix driver with inter-row blanking
module led_row_scanner #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel_in,
  output logic [3:0]  row_sel,
  output logic [15:0] col_out,
  output logic [15:0] row_en,
  output logic        frame_start
);

  import matrix_pkg::*;

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC) + 1;

  scan_state_t state_q;
  scan_state_t state_d;
  logic [3:0]  row_q;
  logic [3:0]  row_d;
  row_t        col_q;
  row_t        col_d;
  row_t        en_q;
  row_t        en_d;

  logic          tc;
  logic          cnt_clear;
  logic [CW-1:0] cnt_last;

  // One counter serves both phases; its terminal value follows the current state
  assign cnt_last  = (state_q == matrix_pkg::SHOW) ? CW'(DWELL - 1) : CW'(BLANK - 1);
  assign cnt_clear = tc || (state_q == matrix_pkg::FETCH);

  scan_counter #(
    .W (CW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .last_i  (cnt_last),
    .tc_o    (tc)
  );

  // Scan sequencing: dark gap, single-cycle capture, then hold the row lit
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    en_d    = en_q;
    unique case (state_q)
      matrix_pkg::BLANK: begin
        if (tc) begin
          state_d = matrix_pkg::FETCH;
        end
      end
      matrix_pkg::FETCH: begin
        col_d   = pixel_in;
        en_d    = row_t'(1) << row_q;
        state_d = matrix_pkg::SHOW;
      end
      matrix_pkg::SHOW: begin
        if (tc) begin
          col_d   = '0;
          en_d    = '0;
          row_d   = row_q + 4'd1;
          state_d = matrix_pkg::BLANK;
        end
      end
      default: begin
        state_d = matrix_pkg::BLANK;
      end
    endcase
  end

  // State and output registers; reset abandons any partially shown row
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= matrix_pkg::BLANK;
      row_q   <= '0;
      col_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      en_q    <= en_d;
    end
  end

  assign row_sel     = row_q;
  assign col_out     = col_q;
  assign row_en      = en_q;
  assign frame_start = (state_q == matrix_pkg::FETCH) && (row_q == 4'd0);

endmodule

// File: tb/tb_led_row_scanner.sv
// tb/tb_led_row_scanner.sv - self-checking bench for led_row_scanner at two DWELL/BLANK settings
module tb_led_row_scanner;

  localparam int DW_A = 4;
  localparam int BL_A = 2;
  localparam int DW_B = 1;
  localparam int BL_B = 1;

  logic        clk;
  logic        reset;
  logic [15:0] pixel_in;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] col_a, col_b, en_a, en_b;
  logic        fs_a, fs_b;

  led_row_scanner #(.DWELL(DW_A), .BLANK(BL_A)) dut_a (
    .clk(clk), .reset(reset), .pixel_in(pixel_in),
    .row_sel(sel_a), .col_out(col_a), .row_en(en_a), .frame_start(fs_a)
  );

  led_row_scanner #(.DWELL(DW_B), .BLANK(BL_B)) dut_b (
    .clk(clk), .reset(reset), .pixel_in(pixel_in),
    .row_sel(sel_b), .col_out(col_b), .row_en(en_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] en;
    logic [15:0] col;
    logic [3:0]  sel;
    logic        fs;
  } exp_t;

  typedef struct {
    logic [15:0] pix;
    exp_t        e;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int t;
  logic [15:0] cap_a, cap_b;
  int fs_times[$];
  int lit_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  // Expected outputs at cycle t derived from the row/phase arithmetic of the scan
  function automatic exp_t model(input int tc, input int dw, input int bl, input logic [15:0] cap);
    exp_t e;
    int p, r, ph;
    p  = bl + 1 + dw;
    r  = (tc / p) % 16;
    ph = tc % p;
    e.sel = 4'(r);
    e.fs  = (ph == bl) && (r == 0);
    if (ph > bl) begin
      e.en  = 16'(1) << r;
      e.col = cap;
    end else begin
      e.en  = '0;
      e.col = '0;
    end
    return e;
  endfunction

  // mode 0: random every cycle, 1: all-on only while row 3 is selected, 2: constant F697
  task automatic run_cycle(input int mode);
    exp_t ea, eb;
    ea = model(t, DW_A, BL_A, cap_a);
    eb = model(t, DW_B, BL_B, cap_b);
    check("a_row_en", 32'(en_a), 32'(ea.en));
    check("a_col_out", 32'(col_a), 32'(ea.col));
    check("a_row_sel", 32'(sel_a), 32'(ea.sel));
    check("a_frame_start", 32'(fs_a), 32'(ea.fs));
    check("b_row_en", 32'(en_b), 32'(eb.en));
    check("b_col_out", 32'(col_b), 32'(eb.col));
    check("b_row_sel", 32'(sel_b), 32'(eb.sel));
    check("b_frame_start", 32'(fs_b), 32'(eb.fs));
    if (fs_a) fs_times.push_back(t);
    if (en_a == 16'h0008 && col_a == 16'hFFFF) lit_cnt++;
    case (mode)
      0:       pixel_in = 16'($urandom);
      1:       pixel_in = (sel_a == 4'd3) ? 16'hFFFF : 16'h0000;
      default: pixel_in = 16'hF697;
    endcase
    if (t % (BL_A + 1 + DW_A) == BL_A) cap_a = pixel_in;
    if (t % (BL_B + 1 + DW_B) == BL_B) cap_b = pixel_in;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    cap_a = '0;
    cap_b = '0;
  endtask

  vec_t tbl[8];

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      check("tbl_row_en", 32'(en_a), 32'(tbl[i].e.en));
      check("tbl_col_out", 32'(col_a), 32'(tbl[i].e.col));
      check("tbl_row_sel", 32'(sel_a), 32'(tbl[i].e.sel));
      check("tbl_frame_start", 32'(fs_a), 32'(tbl[i].e.fs));
      run_cycle(2);
    end
  endtask

  initial begin
    reset    = 1'b1;
    pixel_in = 16'hF697;
    t        = 0;
    cap_a    = '0;
    cap_b    = '0;
    lit_cnt  = 0;

    tbl[0] = '{16'hF697, '{16'h0000, 16'h0000, 4'd0, 1'b0}};
    tbl[1] = '{16'hF697, '{16'h0000, 16'h0000, 4'd0, 1'b0}};
    tbl[2] = '{16'hF697, '{16'h0000, 16'h0000, 4'd0, 1'b1}};
    tbl[3] = '{16'hF697, '{16'h0001, 16'hF697, 4'd0, 1'b0}};
    tbl[4] = '{16'hF697, '{16'h0001, 16'hF697, 4'd0, 1'b0}};
    tbl[5] = '{16'hF697, '{16'h0001, 16'hF697, 4'd0, 1'b0}};
    tbl[6] = '{16'hF697, '{16'h0001, 16'hF697, 4'd0, 1'b0}};
    tbl[7] = '{16'hF697, '{16'h0000, 16'h0000, 4'd1, 1'b0}};

    // Reset release with a constant pattern
    do_reset();
    check("reset_row_en", 32'(en_a), 32'h0);
    check("reset_col_out", 32'(col_a), 32'h0);
    run_table();

    // Two full frames of random pixels, including the row 15 -> 0 wrap
    while (t < 230) begin
      if (t == 111) check("wrap_sel_15", 32'(sel_a), 32'd15);
      if (t == 112) check("wrap_sel_0", 32'(sel_a), 32'd0);
      run_cycle(0);
    end
    check("fs_count", 32'(fs_times.size()), 32'd3);
    if (fs_times.size() >= 3) begin
      check("fs_first", 32'(fs_times[0]), 32'd2);
      check("fs_second", 32'(fs_times[1]), 32'd114);
      check("fs_third", 32'(fs_times[2]), 32'd226);
    end

    // Only row 3 carries pixels: lit for exactly DWELL cycles in a frame
    do_reset();
    lit_cnt = 0;
    while (t < 112) run_cycle(1);
    check("row3_lit_cycles", 32'(lit_cnt), 32'd4);

    // Reset pulse in the middle of row 9's display
    do_reset();
    while (t < 67) run_cycle(0);
    check("pre_reset_row9", 32'(en_a), 32'h0200);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    cap_a = '0;
    cap_b = '0;
    check("midreset_row_en", 32'(en_a), 32'h0);
    check("midreset_col_out", 32'(col_a), 32'h0);
    check("midreset_row_sel", 32'(sel_a), 32'h0);
    run_table();

    // Minimal DWELL=1/BLANK=1 instance: frame_start every 48 cycles
    do_reset();
    fs_times.delete();
    begin
      int fsb[$];
      while (t < 150) begin
        if (fs_b) fsb.push_back(t);
        run_cycle(0);
      end
      check("b_fs_count", 32'(fsb.size()), 32'd4);
      for (int i = 0; i + 1 < fsb.size(); i++) begin
        check("b_fs_period", 32'(fsb[i+1] - fsb[i]), 32'd48);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_row_scanner.md
# led_row_scanner

Row-multiplexing reader for the 16x16 LED matrix. Game-state blocks such as the frog, lane, and game-over overlays each drive a 16-bit `pixels` row pattern for the currently selected row. This block selects each row in turn and captures that row's pattern. It drives the column lines and a one-hot row enable, inserting a blanking gap between rows to prevent ghosting. It sits between the OR-combined pixel sources and the board's matrix pins.

## Interface
Parameters:
- `DWELL`, default 1024: cycles a row is lit; legal range ≥1.
- `BLANK`, default 16: cycles all rows are dark before each row is lit; legal range ≥1.

Ports:
- `clk`, input, 1 bit: system clock.
- `reset`, input, 1 bit: synchronous, active-high.
- `pixel_in`, input, 16 bits: row pattern for the row given by `row_sel`. Bit i maps to column i; 1 means lit.
- `row_sel`, output, 4 bits: index of the row being fetched or shown. Pixel sources decode this.
- `col_out`, output, 16 bits: registered column drive; active-high.
- `row_en`, output, 16 bits: registered one-hot row enable; all zero while blanking.
- `frame_start`, output, 1 bit: one-cycle pulse marking the start of row 0 display.

## Operation
- FSM states: BLANK, FETCH, SHOW. Row counter `row` is 4 bits; dwell/blank counter `cnt` is sized `$clog2(max(DWELL,BLANK))+1`.
- BLANK:
  - `row_en`=0 and `col_out`=0.
  - `row_sel`=`row`.
  - Counts BLANK cycles, then goes to FETCH.
- FETCH (exactly 1 cycle):
  - `row_sel`=`row`.
  - At the clock edge: `col_out` <= `pixel_in`, `row_en` <= (1<<`row`), `cnt` cleared, then go to SHOW.
  - `frame_start` is high during this cycle iff `row`==0.
- SHOW:
  - Outputs hold the captured values; changes on `pixel_in` are ignored.
  - Counts DWELL cycles. On the last one: `row_en`, `col_out` <= 0; `row` <= `row`+1 (15 wraps to 0); go to BLANK.
- `row_sel` changes only when entering BLANK. Pixel sources therefore have the full BLANK period to settle before FETCH samples `pixel_in`.
- Reset dominates all states, including mid-SHOW. It forces the reset values on the next edge; no partial row completes.

## Timing
- Reset values: state=BLANK, `row`=0, `cnt`=0, `row_sel`=0, `col_out`=0, `row_en`=0, `frame_start`=0.
- Cycle 0 is the first cycle with `reset` low.
  - Cycles 0..BLANK-1: BLANK.
  - Cycle BLANK: FETCH, with `frame_start`=1.
  - Cycles BLANK+1..BLANK+DWELL: `row_en`/`col_out` show row 0.
- Row period = BLANK+1+DWELL cycles. Frame period = 16×(BLANK+1+DWELL).
- Capture latency: the `pixel_in` value in the FETCH cycle appears on `col_out` exactly 1 cycle later.
- Never more than one bit of `row_en` is set. `row_en` and `col_out` are nonzero only in SHOW cycles.
- `frame_start` recurs every frame period, always in the FETCH cycle of row 0.

## Structure
- Shared package `matrix_pkg`:
  - `NUM_ROWS`=16, `NUM_COLS`=16.
  - `typedef enum {BLANK, FETCH, SHOW} scan_state_t`.
  - `typedef logic [15:0] row_t`.
- One natural sub-module, `scan_counter`: a loadable up-counter with a terminal-count flag, reused for both the BLANK and DWELL counts. Everything else stays in `led_row_scanner`.

## Test plan
All scenarios use DWELL=4, BLANK=2 unless stated (row period 7, frame 112).
- Reset release with `pixel_in`=16'hF697 held:
  - `row_en`=0 and `col_out`=0 for cycles 0..2.
  - `frame_start`=1 at cycle 2 only.
  - Cycles 3..6: `row_en`=16'h0001, `col_out`=16'hF697.
  - Cycle 7: both 0, `row_sel`=1.
- `pixel_in`=16'hFFFF while `row_sel`=3, else 0:
  - `row_en`=16'h0008 with `col_out`=16'hFFFF for exactly 4 cycles per frame.
  - All other rows show `col_out`=0.
- Toggle `pixel_in` every cycle during SHOW of row 5: `col_out` stays equal to the value sampled in FETCH for all 4 cycles.
- Run 2 full frames:
  - `frame_start` pulses at cycles 2 and 114.
  - `row_sel` wraps 15→0 at cycle 112.
  - `row_en` one-hot or zero on every cycle.
- Assert `reset` for 1 cycle during SHOW of row 9: next cycle `row_en`=0, `col_out`=0, `row_sel`=0, and the sequence restarts as in the first scenario.
- DWELL=1, BLANK=1: row period 3; each row lit exactly 1 cycle; `frame_start` every 48 cycles.
